// File: rtl/instr_queue_issue_pkg.sv
// Shared types and helpers for the instruction queue issue block.
package instr_queue_issue_pkg;

  localparam int IQ_DEPTH_DEFAULT = 8;
  localparam int IQ_AGE_WIDTH     = 32;

  typedef logic [5:0] MipsReg;

  typedef struct packed {
    logic                    valid;
    logic                    ready;
    logic [IQ_AGE_WIDTH-1:0] count;
    logic [31:0]             pc;
    logic [5:0]              opcode;
    MipsReg                  rs_phys;
    MipsReg                  rt_phys;
    MipsReg                  rd_phys;
    logic                    uses_rs;
    logic                    uses_rt;
  } Instr_Queue_Entry_t;

  // Wrap-safe age compare: a is older than b when (a - b) is negative.
  function automatic logic iq_older(input logic [IQ_AGE_WIDTH-1:0] a,
                                    input logic [IQ_AGE_WIDTH-1:0] b);
    logic [IQ_AGE_WIDTH-1:0] diff;
    diff = a - b;
    return diff[IQ_AGE_WIDTH-1];
  endfunction

endpackage

// File: rtl/instr_queue_issue_if.sv
// Enqueue, wakeup, issue and flush signals between rename, the queue and execute.
interface instr_queue_issue_if
  import instr_queue_issue_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH_DEFAULT
) ();
  localparam int OCC_W = $clog2(DEPTH) + 1;

  logic               in_valid;
  logic               in_ready;
  Instr_Queue_Entry_t in_entry;
  logic               in_rs_rdy;
  logic               in_rt_rdy;
  logic               wb_valid;
  MipsReg             wb_phys;
  logic               out_valid;
  logic               out_ready;
  Instr_Queue_Entry_t out_entry;
  logic               flush;
  logic [OCC_W-1:0]   occupancy;

  modport master (
    output in_valid, in_entry, in_rs_rdy, in_rt_rdy, wb_valid, wb_phys, out_ready, flush,
    input  in_ready, out_valid, out_entry, occupancy
  );

  modport slave (
    input  in_valid, in_entry, in_rs_rdy, in_rt_rdy, wb_valid, wb_phys, out_ready, flush,
    output in_ready, out_valid, out_entry, occupancy
  );
endinterface

// File: rtl/iq_age_select.sv
// Oldest-ready picker: linear scan keeping the oldest ready slot seen so far.
module iq_age_select
  import instr_queue_issue_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH_DEFAULT
) (
  input  logic [DEPTH-1:0]                   rdy,
  input  logic [DEPTH-1:0][IQ_AGE_WIDTH-1:0] count,
  output logic [$clog2(DEPTH)-1:0]           grant,
  output logic                               any_ready
);
  localparam int IDX_W = $clog2(DEPTH);

  logic [IQ_AGE_WIDTH-1:0] best;

  always_comb begin
    grant     = '0;
    any_ready = 1'b0;
    best      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rdy[i] && (!any_ready || iq_older(count[i], best))) begin
        any_ready = 1'b1;
        grant     = IDX_W'(i);
        best      = count[i];
      end
    end
  end

endmodule

// File: rtl/instr_queue_issue.sv
// Instruction queue consumer: buffers renamed entries, wakes sources, issues oldest ready.
// Define IQ_WAKEUP_BYPASS_EN to let a wakeup broadcast feed select in the same cycle.
module instr_queue_issue
  import instr_queue_issue_pkg::*;
#(
  parameter int                   DEPTH     = IQ_DEPTH_DEFAULT,
  parameter int                   AGE_WIDTH = IQ_AGE_WIDTH,
  parameter logic [AGE_WIDTH-1:0] AGE_RESET = '0
) (
  input logic                clk,
  input logic                rst,
  instr_queue_issue_if.slave iq
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int OCC_W = IDX_W + 1;

  Instr_Queue_Entry_t                 slot_q [DEPTH];
  logic [DEPTH-1:0]                   valid_q, rs_rdy_q, rt_rdy_q;
  logic [DEPTH-1:0]                   valid_d, rs_rdy_d, rt_rdy_d;
  logic [DEPTH-1:0]                   rs_wake, rt_wake, rs_sel, rt_sel, slot_rdy;
  logic [DEPTH-1:0][IQ_AGE_WIDTH-1:0] slot_count;
  logic [AGE_WIDTH-1:0]               age_q;
  logic [OCC_W-1:0]                   occ_q, occ_d;
  logic [IDX_W-1:0]                   free_idx, grant;
  logic                               any_ready, in_ready_w, enq, iss;
  logic                               in_rs_ok, in_rt_ok;
  Instr_Queue_Entry_t                 ent_in, sel_ent;

  always_comb begin
    rs_wake    = '0;
    rt_wake    = '0;
    slot_count = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rs_wake[i]    = iq.wb_valid && (slot_q[i].rs_phys == iq.wb_phys);
      rt_wake[i]    = iq.wb_valid && (slot_q[i].rt_phys == iq.wb_phys);
      slot_count[i] = slot_q[i].count;
    end
  end

`ifdef IQ_WAKEUP_BYPASS_EN
  assign rs_sel = rs_rdy_q | rs_wake;
  assign rt_sel = rt_rdy_q | rt_wake;
`else
  assign rs_sel = rs_rdy_q;
  assign rt_sel = rt_rdy_q;
`endif

  assign slot_rdy = valid_q & rs_sel & rt_sel;

  iq_age_select #(.DEPTH(DEPTH)) u_select (
    .rdy       (slot_rdy),
    .count     (slot_count),
    .grant     (grant),
    .any_ready (any_ready)
  );

  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i]) free_idx = IDX_W'(i);
    end
  end

  // Capacity is judged on registered occupancy; a slot issuing this cycle is not reusable yet.
  assign in_ready_w = (occ_q != OCC_W'(DEPTH));
  assign enq        = iq.in_valid & in_ready_w & ~iq.flush;
  assign iss        = any_ready & iq.out_ready & ~iq.flush;

  assign in_rs_ok = iq.in_rs_rdy | ~iq.in_entry.uses_rs |
                    (iq.wb_valid && (iq.wb_phys == iq.in_entry.rs_phys));
  assign in_rt_ok = iq.in_rt_rdy | ~iq.in_entry.uses_rt |
                    (iq.wb_valid && (iq.wb_phys == iq.in_entry.rt_phys));

  always_comb begin
    ent_in       = iq.in_entry;
    ent_in.count = IQ_AGE_WIDTH'(age_q);
    ent_in.valid = 1'b1;
    ent_in.ready = in_rs_ok & in_rt_ok;
  end

  always_comb begin
    valid_d  = valid_q;
    rs_rdy_d = rs_rdy_q | rs_wake;
    rt_rdy_d = rt_rdy_q | rt_wake;
    occ_d    = occ_q + OCC_W'(enq) - OCC_W'(iss);
    if (iss) valid_d[grant] = 1'b0;
    if (enq) begin
      valid_d[free_idx]  = 1'b1;
      rs_rdy_d[free_idx] = in_rs_ok;
      rt_rdy_d[free_idx] = in_rt_ok;
    end
    if (iq.flush) begin
      valid_d = '0;
      occ_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= '0;
      rs_rdy_q <= '0;
      rt_rdy_q <= '0;
      occ_q    <= '0;
      age_q    <= AGE_RESET;
    end else begin
      valid_q  <= valid_d;
      rs_rdy_q <= rs_rdy_d;
      rt_rdy_q <= rt_rdy_d;
      occ_q    <= occ_d;
      if (enq) age_q <= age_q + 1'b1;
    end
  end

  // Payload storage needs no reset: a slot is only observed while its valid bit is set.
  always_ff @(posedge clk) begin
    if (enq) slot_q[free_idx] <= ent_in;
  end

  always_comb begin
    sel_ent       = slot_q[grant];
    sel_ent.valid = 1'b1;
    sel_ent.ready = 1'b1;
    iq.out_entry  = any_ready ? sel_ent : '0;
  end

  assign iq.out_valid = any_ready;
  assign iq.in_ready  = in_ready_w;
  assign iq.occupancy = occ_q;

endmodule

// File: tb/tb_instr_queue_issue.sv
// Scoreboard bench for instr_queue_issue: directed stimulus, monitor checks issued entries in order.
module tb_instr_queue_issue;
  import instr_queue_issue_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  instr_queue_issue_if #(.DEPTH(8)) iq ();
  instr_queue_issue_if #(.DEPTH(8)) iqw ();

  instr_queue_issue #(.DEPTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .iq  (iq)
  );

  instr_queue_issue #(.DEPTH(8), .AGE_RESET(32'hFFFF_FFFF)) dut_w (
    .clk (clk),
    .rst (rst),
    .iq  (iqw)
  );

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic void push_exp(input logic [31:0] pc, input logic [31:0] cnt);
    exp_q.push_back({2'b11, pc[29:0], cnt});
  endfunction

  function automatic Instr_Queue_Entry_t mk(input logic [31:0] pc, input MipsReg rs, input MipsReg rt,
                                            input logic urs, input logic urt);
    Instr_Queue_Entry_t e;
    e         = '0;
    e.pc      = pc;
    e.count   = 32'hDEAD_BEEF;
    e.ready   = 1'b1;
    e.opcode  = 6'h23;
    e.rs_phys = rs;
    e.rt_phys = rt;
    e.rd_phys = 6'd1;
    e.uses_rs = urs;
    e.uses_rt = urt;
    return e;
  endfunction

  // Monitor: every accepted issue must match the head of the expected queue.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (!rst && !iq.flush && iq.out_valid && iq.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: got pc 0x%0h expected no issue", iq.out_entry.pc);
        end else begin
          e = exp_q.pop_front();
          check("sb_issue", {iq.out_entry.ready, iq.out_entry.valid, iq.out_entry.pc[29:0],
                             iq.out_entry.count}, e);
        end
      end
    end
  end

  initial begin
    {iq.in_valid, iq.in_rs_rdy, iq.in_rt_rdy, iq.wb_valid, iq.out_ready, iq.flush} = '0;
    {iqw.in_valid, iqw.in_rs_rdy, iqw.in_rt_rdy, iqw.wb_valid, iqw.out_ready, iqw.flush} = '0;
    iq.wb_phys   = '0;
    iqw.wb_phys  = '0;
    iq.in_entry  = '0;
    iqw.in_entry = '0;

    repeat (3) @(negedge clk);
    check("rst_in_ready", 64'(iq.in_ready), 64'd1);
    check("rst_out_valid", 64'(iq.out_valid), 64'd0);
    check("rst_occupancy", 64'(iq.occupancy), 64'd0);
    check("rst_out_entry_zero", 64'(iq.out_entry == '0), 64'd1);
    rst = 1'b0;

    // Single ready entry: visible one cycle later with count 0.
    iq.in_valid  = 1'b1;
    iq.in_entry  = mk(32'd100, 6'd2, 6'd3, 1'b1, 1'b1);
    iq.in_rs_rdy = 1'b1;
    iq.in_rt_rdy = 1'b1;
    @(negedge clk);
    iq.in_valid = 1'b0;
    check("one_out_valid", 64'(iq.out_valid), 64'd1);
    check("one_pc", 64'(iq.out_entry.pc), 64'd100);
    check("one_count", 64'(iq.out_entry.count), 64'd0);
    check("one_occupancy", 64'(iq.occupancy), 64'd1);
    push_exp(32'd100, 32'd0);
    iq.out_ready = 1'b1;
    @(negedge clk);
    iq.out_ready = 1'b0;
    check("one_drained_occ", 64'(iq.occupancy), 64'd0);
    check("one_drained_valid", 64'(iq.out_valid), 64'd0);

    // Fill all 8 slots with issue blocked; counts 1..8.
    for (int i = 0; i < 8; i++) begin
      if (i == 7) begin
        check("fill7_occ", 64'(iq.occupancy), 64'd7);
        check("fill7_in_ready", 64'(iq.in_ready), 64'd1);
      end
      iq.in_valid = 1'b1;
      iq.in_entry = mk(32'd200 + 32'(i), 6'd4, 6'd5, 1'b1, 1'b1);
      @(negedge clk);
    end
    check("full_in_ready", 64'(iq.in_ready), 64'd0);
    check("full_occ", 64'(iq.occupancy), 64'd8);
    iq.in_entry = mk(32'd299, 6'd4, 6'd5, 1'b1, 1'b1);
    @(negedge clk);
    iq.in_valid = 1'b0;
    check("ninth_dropped_occ", 64'(iq.occupancy), 64'd8);

    // Output held stable under back-pressure, then one issue frees a slot.
    for (int k = 0; k < 3; k++) begin
      check("hold_pc", 64'(iq.out_entry.pc), 64'd200);
      check("hold_count", 64'(iq.out_entry.count), 64'd1);
      @(negedge clk);
    end
    push_exp(32'd200, 32'd1);
    iq.out_ready = 1'b1;
    @(negedge clk);
    iq.out_ready = 1'b0;
    check("release_occ", 64'(iq.occupancy), 64'd7);
    check("release_next_pc", 64'(iq.out_entry.pc), 64'd201);

    // Refill, then flush with a competing enqueue.
    iq.in_valid = 1'b1;
    iq.in_entry = mk(32'd208, 6'd4, 6'd5, 1'b1, 1'b1);
    @(negedge clk);
    check("refill_occ", 64'(iq.occupancy), 64'd8);
    iq.in_entry = mk(32'd209, 6'd4, 6'd5, 1'b1, 1'b1);
    iq.flush    = 1'b1;
    @(negedge clk);
    iq.flush    = 1'b0;
    iq.in_valid = 1'b0;
    check("flush_occ", 64'(iq.occupancy), 64'd0);
    check("flush_out_valid", 64'(iq.out_valid), 64'd0);
    check("flush_in_ready", 64'(iq.in_ready), 64'd1);
    @(negedge clk);
    check("flush_nothing_enq", 64'(iq.out_valid), 64'd0);

    // A waits on p12 (count 10), B ready (count 11): B first, A after wakeup.
    iq.in_valid  = 1'b1;
    iq.in_entry  = mk(32'd300, 6'd12, 6'd0, 1'b1, 1'b0);
    iq.in_rs_rdy = 1'b0;
    iq.in_rt_rdy = 1'b0;
    @(negedge clk);
    iq.in_entry  = mk(32'd301, 6'd5, 6'd6, 1'b1, 1'b1);
    iq.in_rs_rdy = 1'b1;
    iq.in_rt_rdy = 1'b1;
    @(negedge clk);
    iq.in_valid = 1'b0;
    check("ab_b_first_pc", 64'(iq.out_entry.pc), 64'd301);
    push_exp(32'd301, 32'd11);
    iq.out_ready = 1'b1;
    @(negedge clk);
    iq.out_ready = 1'b0;
    check("ab_a_blocked", 64'(iq.out_valid), 64'd0);
    check("ab_occ", 64'(iq.occupancy), 64'd1);
    iq.wb_valid = 1'b1;
    iq.wb_phys  = 6'd13;
    @(negedge clk);
    check("ab_decoy_no_wake", 64'(iq.out_valid), 64'd0);
    iq.wb_phys = 6'd12;
    #1;
`ifdef IQ_WAKEUP_BYPASS_EN
    check("ab_wake_same_cycle", 64'(iq.out_valid), 64'd1);
`else
    check("ab_wake_same_cycle", 64'(iq.out_valid), 64'd0);
`endif
    @(negedge clk);
    iq.wb_valid = 1'b0;
    check("ab_a_valid", 64'(iq.out_valid), 64'd1);
    check("ab_a_pc", 64'(iq.out_entry.pc), 64'd300);
    push_exp(32'd300, 32'd10);
    iq.out_ready = 1'b1;
    @(negedge clk);
    iq.out_ready = 1'b0;
    check("ab_done_occ", 64'(iq.occupancy), 64'd0);

    // Wakeup coinciding with enqueue is captured into the new slot.
    iq.in_valid  = 1'b1;
    iq.in_entry  = mk(32'd400, 6'd20, 6'd3, 1'b1, 1'b1);
    iq.in_rs_rdy = 1'b0;
    iq.in_rt_rdy = 1'b1;
    iq.wb_valid  = 1'b1;
    iq.wb_phys   = 6'd20;
    @(negedge clk);
    iq.in_valid = 1'b0;
    iq.wb_valid = 1'b0;
    check("enq_wake_valid", 64'(iq.out_valid), 64'd1);
    check("enq_wake_count", 64'(iq.out_entry.count), 64'd12);
    push_exp(32'd400, 32'd12);
    iq.out_ready = 1'b1;
    @(negedge clk);
    iq.out_ready = 1'b0;

    // Age wrap on the second instance: X=FFFFFFFF is older than Y=0.
    iqw.in_valid  = 1'b1;
    iqw.in_rs_rdy = 1'b1;
    iqw.in_rt_rdy = 1'b1;
    iqw.in_entry  = mk(32'd500, 6'd7, 6'd8, 1'b1, 1'b1);
    @(negedge clk);
    iqw.in_entry = mk(32'd501, 6'd7, 6'd8, 1'b1, 1'b1);
    @(negedge clk);
    iqw.in_valid = 1'b0;
    check("wrap_occ", 64'(iqw.occupancy), 64'd2);
    check("wrap_x_pc", 64'(iqw.out_entry.pc), 64'd500);
    check("wrap_x_count", 64'(iqw.out_entry.count), 64'hFFFF_FFFF);
    iqw.out_ready = 1'b1;
    @(negedge clk);
    iqw.out_ready = 1'b0;
    check("wrap_y_pc", 64'(iqw.out_entry.pc), 64'd501);
    check("wrap_y_count", 64'(iqw.out_entry.count), 64'd0);
    iqw.out_ready = 1'b1;
    @(negedge clk);
    iqw.out_ready = 1'b0;
    check("wrap_empty", 64'(iqw.out_valid), 64'd0);

    repeat (2) @(negedge clk);
    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
